bp_axil_nbf_assembler: RTL and testbench
========================================

# bp_axil_nbf_assembler

AXI4-Lite slave that terminates the NBF write stream produced by the host-side NBF loader. It reassembles five 32-bit flits into one 136-bit NBF command (opcode, addr, data) and presents it on a valid/ready port to the BlackParrot-side command consumer. It also buffers 32-bit responses from that side and exposes them through a count register (0x10) and a pop-on-read data register (0x14). It sits directly downstream of the loader on the FPGA shell's AXI-Lite fabric.

## Interface
- S_AXIL_ADDR_WIDTH, 64, AXI-Lite address width
- S_AXIL_DATA_WIDTH, 32, data width; only 32 supported
- nbf_host_addr_p, 64'h0, write address accepted as NBF flit stream
- resp_els_p, 16, response FIFO depth (power of 2, >=2)
- s_axil_aclk  in  1  clock
- s_axil_aresetn  in  1  reset, asynchronous, active-low
- s_axil_awaddr/awvalid/awready/awprot  in/in/out/in  ADDR/1/1/3  write address channel
- s_axil_wdata/wvalid/wready/wstrb  in/in/out/in  32/1/1/4  write data channel
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s_axil_araddr/arvalid/arready/arprot  in/in/out/in  ADDR/1/1/3  read address
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
- nbf_o  out  136  {opcode[7:0], addr[63:0], data[63:0]}
- nbf_v_o  out  1  command valid
- nbf_ready_and_i  in  1  consumer accepts
- resp_data_i  in  32  response word
- resp_v_i  in  1  response valid
- resp_ready_and_o  out  1  FIFO not full
- done_o  out  1  finish observed (see Configuration)

## Operation
- Flit order: word0=data[31:0], word1=data[63:32], word2=addr[31:0], word3=addr[63:32], word4 low byte=opcode, upper 24 bits ignored. wstrb and prot ignored.
- AW and W each have a one-entry holding register; awready=~aw_full, wready=~w_full; channels accepted independently in any order.
- Commit when aw_full & w_full & (~bvalid | bready). Word 4 additionally requires output slot free (~nbf_v_o | nbf_ready_and_i). Commit clears both holds, sets bvalid.
- awaddr==nbf_host_addr_p: bresp=OKAY, flit stored, word counter 0..4 increments; on word 4 the assembled command loads nbf_o, nbf_v_o=1, counter wraps to 0.
- Other address: bresp=SLVERR(2'b10), data dropped, counter unchanged.
- nbf_v_o held with stable nbf_o until nbf_ready_and_i.
- Reads: arready=~rvalid. On AR handshake, rdata registered, rvalid=1 next cycle, held until rready.
  - 0x10: FIFO occupancy zero-extended, OKAY.
  - 0x14: FIFO head, popped on AR handshake, OKAY; if empty, rdata=0, OKAY, no pop.
  - Other: rdata=0, SLVERR.
- Response FIFO: push when resp_v_i & resp_ready_and_o; simultaneous push and pop allowed at any occupancy, including full (count unchanged) and empty (pop sees empty, push lands).

## Timing
- Reset values: awready=wready=arready=1, bvalid=rvalid=nbf_v_o=resp_ready_and_o(1 once out of reset)=0 except ready outputs; rdata=bresp=rresp=0, nbf_o=0, done_o=0, counter=0, FIFO empty.
- Reset asserted mid-command discards partial flits, holds, pending B/R and FIFO contents.
- AW and W in same cycle t -> bvalid at t+2 (hold at t+1, commit edge t+1). Word-4 commit at edge t+1 -> nbf_v_o at t+2 same cycle as bvalid.
- AR at t -> rvalid at t+1. Occupancy read at t reflects pushes/pops completed before edge t.
- Back-to-back writes: one flit per 2 cycles when bready held 1 and AW/W re-presented immediately.
- Stalled output (nbf_v_o=1, ready=0): next command's word 0-3 still commit; word 4 stalls, holding awready=wready=0.

## Configuration
- BP_AXIL_NBF_ASSEMBLER_FINISH_EN defined: opcode 8'hFF consumed locally — not forwarded on nbf_v_o, sets sticky done_o (cleared only by reset); B response still OKAY. Further flits after finish still accepted normally.
- Undefined: 8'hFF forwarded like any command; done_o tied 0.

## Test plan
- Write 5 flits {0x89ABCDEF,0x01234567,0x80000000,0x0,0x03} to host addr -> one nbf_v_o, nbf_o={8'h03,64'h80000000,64'h0123456789ABCDEF}, five OKAY bresps.
- Same stream with W before AW by 3 cycles per flit, bready low 4 cycles -> identical nbf_o, no lost/duplicate flit, bvalid held stable.
- Write to 0x20 between flits 2 and 3 -> SLVERR, command still correct on flit 5.
- nbf_ready_and_i=0 for 20 cycles with two commands streamed -> second command's word 4 stalls awready/wready; both commands delivered in order.
- Push 3 responses 0x11,0x22,0x33 -> read 0x10=3, three 0x14 reads return 0x11,0x22,0x33, fourth returns 0; fill to 16, resp_ready_and_o=0, push+pop same cycle keeps count 16.
- With FINISH_EN: send opcode 0xFF -> done_o=1, no nbf_v_o; assert reset mid second command -> done_o=0, counter 0.

Source files
------------

// File: rtl/bp_axil_nbf_assembler.sv
// AXI4-Lite slave: assembles five 32-bit NBF flits into a 136-bit command and buffers 32-bit responses (optional BP_AXIL_NBF_ASSEMBLER_FINISH_EN).
// Latency: AW+W accepted at t -> bvalid (and nbf_v_o on word 4) at t+2; AR at t -> rvalid at t+1.
// Backpressure: one-entry AW/W holds; word 4 stalls in the holds while the command slot is occupied.
module bp_axil_nbf_assembler #(
    parameter int          S_AXIL_ADDR_WIDTH = 64,
    parameter int          S_AXIL_DATA_WIDTH = 32,
    parameter logic [63:0] nbf_host_addr_p   = 64'h0,
    parameter int          resp_els_p        = 16
) (
    input  logic                           s_axil_aclk,
    input  logic                           s_axil_aresetn,
    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [2:0]                     s_axil_awprot,
    input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready,
    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    input  logic [2:0]                     s_axil_arprot,
    output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,
    output logic [135:0]                   nbf_o,
    output logic                           nbf_v_o,
    input  logic                           nbf_ready_and_i,
    input  logic [31:0]                    resp_data_i,
    input  logic                           resp_v_i,
    output logic                           resp_ready_and_o,
    output logic                           done_o
);
    localparam int LP_CW = $clog2(resp_els_p);
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] LP_HOST     = nbf_host_addr_p[S_AXIL_ADDR_WIDTH-1:0];
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] LP_CNT_ADDR = S_AXIL_ADDR_WIDTH'(8'h10);
    localparam logic [S_AXIL_ADDR_WIDTH-1:0] LP_DAT_ADDR = S_AXIL_ADDR_WIDTH'(8'h14);
    localparam logic [LP_CW:0]               LP_FULL     = (LP_CW+1)'(resp_els_p);
    localparam logic [1:0] LP_OKAY   = 2'b00;
    localparam logic [1:0] LP_SLVERR = 2'b10;

    logic                         r_aw_full, r_w_full;
    logic [S_AXIL_ADDR_WIDTH-1:0] r_aw_addr;
    logic [S_AXIL_DATA_WIDTH-1:0] r_w_data;
    logic                         r_bvalid;
    logic [1:0]                   r_bresp;
    logic [2:0]                   r_cnt;
    logic [63:0]                  r_data, r_addr;
    logic [135:0]                 r_nbf;
    logic                         r_nbf_v;
    logic                         r_rvalid;
    logic [S_AXIL_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                   r_rresp;
    logic [31:0]                  r_mem [resp_els_p];
    logic [LP_CW-1:0]             r_wptr, r_rptr;
    logic [LP_CW:0]               r_count;

    logic w_host, w_last, w_commit, w_finish;
    logic w_ar_hs, w_empty, w_push, w_pop;
    logic w_unused;

    assign w_host   = (r_aw_addr == LP_HOST);
    assign w_last   = w_host & (r_cnt == 3'd4);
    // Only the final flit needs the command slot; earlier flits land in the staging registers.
    assign w_commit = r_aw_full & r_w_full & (~r_bvalid | s_axil_bready)
                    & (~w_last | ~r_nbf_v | nbf_ready_and_i);

`ifdef BP_AXIL_NBF_ASSEMBLER_FINISH_EN
    logic r_done;
    assign w_finish = (r_w_data[7:0] == 8'hFF);
    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn)              r_done <= 1'b0;
        else if (w_commit & w_last & w_finish) r_done <= 1'b1;
    end
    assign done_o = r_done;
`else
    assign w_finish = 1'b0;
    assign done_o   = 1'b0;
`endif

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= LP_OKAY;
            r_cnt     <= 3'd0;
            r_data    <= '0;
            r_addr    <= '0;
            r_nbf     <= '0;
            r_nbf_v   <= 1'b0;
        end else begin
            if (s_axil_awvalid & ~r_aw_full) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= s_axil_awaddr;
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end
            if (s_axil_wvalid & ~r_w_full) begin
                r_w_full <= 1'b1;
                r_w_data <= s_axil_wdata;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_host ? LP_OKAY : LP_SLVERR;
            end else if (s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_commit & w_host) begin
                case (r_cnt)
                    3'd0:    r_data[31:0]  <= r_w_data[31:0];
                    3'd1:    r_data[63:32] <= r_w_data[31:0];
                    3'd2:    r_addr[31:0]  <= r_w_data[31:0];
                    3'd3:    r_addr[63:32] <= r_w_data[31:0];
                    default: ;
                endcase
                r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
            end
            if (w_commit & w_last & ~w_finish) begin
                r_nbf   <= {r_w_data[7:0], r_addr, r_data};
                r_nbf_v <= 1'b1;
            end else if (nbf_ready_and_i) begin
                r_nbf_v <= 1'b0;
            end
        end
    end

    assign w_ar_hs = s_axil_arvalid & ~r_rvalid;
    assign w_empty = (r_count == '0);
    assign w_pop   = w_ar_hs & (s_axil_araddr == LP_DAT_ADDR) & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign resp_ready_and_o = (r_count != LP_FULL) | w_pop;
    assign w_push  = resp_v_i & resp_ready_and_o;

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= LP_OKAY;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                if (s_axil_araddr == LP_CNT_ADDR) begin
                    r_rdata <= S_AXIL_DATA_WIDTH'(r_count);
                    r_rresp <= LP_OKAY;
                end else if (s_axil_araddr == LP_DAT_ADDR) begin
                    r_rdata <= w_empty ? '0 : r_mem[r_rptr];
                    r_rresp <= LP_OKAY;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= LP_SLVERR;
                end
            end else if (s_axil_rready) begin
                r_rvalid <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_axil_aclk) begin
        if (w_push) r_mem[r_wptr] <= resp_data_i;
    end

    assign s_axil_awready = ~r_aw_full;
    assign s_axil_wready  = ~r_w_full;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = ~r_rvalid;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign nbf_o          = r_nbf;
    assign nbf_v_o        = r_nbf_v;
    assign w_unused       = &{1'b0, s_axil_awprot, s_axil_wstrb, s_axil_arprot};
endmodule

// File: tb/tb_bp_axil_nbf_assembler.sv
// Randomized bench for bp_axil_nbf_assembler against a flit/queue reference model.
module tb_bp_axil_nbf_assembler;
    localparam logic [63:0] HOST = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_axil_awaddr;  logic s_axil_awvalid; logic s_axil_awready; logic [2:0] s_axil_awprot;
    logic [31:0] s_axil_wdata;   logic s_axil_wvalid;  logic s_axil_wready;  logic [3:0] s_axil_wstrb;
    logic [1:0]  s_axil_bresp;   logic s_axil_bvalid;  logic s_axil_bready;
    logic [63:0] s_axil_araddr;  logic s_axil_arvalid; logic s_axil_arready; logic [2:0] s_axil_arprot;
    logic [31:0] s_axil_rdata;   logic [1:0] s_axil_rresp; logic s_axil_rvalid; logic s_axil_rready;
    logic [135:0] nbf_o; logic nbf_v_o; logic nbf_ready_and_i;
    logic [31:0] resp_data_i; logic resp_v_i; logic resp_ready_and_o; logic done_o;

    bp_axil_nbf_assembler #(.S_AXIL_ADDR_WIDTH(64), .S_AXIL_DATA_WIDTH(32),
                            .nbf_host_addr_p(HOST), .resp_els_p(16)) dut (
        .s_axil_aclk(clk), .s_axil_aresetn(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awprot(s_axil_awprot),
        .s_axil_wdata(s_axil_wdata), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_arprot(s_axil_arprot),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i),
        .resp_data_i(resp_data_i), .resp_v_i(resp_v_i), .resp_ready_and_o(resp_ready_and_o), .done_o(done_o));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic prev_v = 1'b0;
    logic [135:0] last_nbf = '0;
    logic [135:0] exp_cmd;
    logic [135:0] exp_q[$];
    logic [31:0]  fifo_q[$];
    logic [31:0]  flit_w[5];
    int           flit_k = 0;
    logic         exp_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Delivery monitor: every accepted command must be the oldest one the model produced.
    always @(negedge clk) begin
        if (rst_n) begin
            if (nbf_v_o && !prev_v) rise_cyc = cyc;
            if (nbf_v_o && nbf_ready_and_i) begin
                n_cmp++;
                last_nbf = nbf_o;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL nbf_unexpected: got %h, required no command", nbf_o);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    if (nbf_o !== exp_cmd) begin
                        n_err++; $display("FAIL nbf_cmd: got %h, required %h", nbf_o, exp_cmd);
                    end
                end
            end
        end
        prev_v = rst_n && nbf_v_o;
    end

    task automatic model_write(input logic [63:0] a, input logic [31:0] d, output logic [1:0] r);
        bit fin;
        fin = 0;
        if (a == HOST) begin
            r = 2'b00;
            flit_w[flit_k] = d;
            flit_k++;
            if (flit_k == 5) begin
                flit_k = 0;
`ifdef BP_AXIL_NBF_ASSEMBLER_FINISH_EN
                fin = (flit_w[4][7:0] == 8'hFF);
`endif
                if (fin) exp_done = 1'b1;
                else exp_q.push_back({flit_w[4][7:0], flit_w[3], flit_w[2], flit_w[1], flit_w[0]});
            end
        end else begin
            r = 2'b10;
        end
    endtask

    task automatic axi_write(input logic [63:0] a, input logic [31:0] d, input int w_lead, input int b_hold,
                             output logic [1:0] resp, output int lat, output int b_cyc);
        int t; int hs_cyc; int waited; bit aw_done, w_done, seen, got_b, aw_hs, w_hs;
        t = 0; hs_cyc = -1; waited = 0; aw_done = 0; w_done = 0; seen = 0; got_b = 0;
        resp = 2'bxx; lat = -1; b_cyc = -1;
        s_axil_awaddr = a; s_axil_wdata = d;
        s_axil_wstrb = 4'($urandom); s_axil_awprot = 3'($urandom);
        s_axil_wvalid = 1'b1; s_axil_awvalid = (w_lead == 0);
        s_axil_bready = (b_hold == 0);
        while (!(aw_done && w_done) && t < 400) begin
            @(negedge clk);
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            if ((aw_hs || aw_done) && (w_hs || w_done) && hs_cyc < 0) hs_cyc = cyc;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; s_axil_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_axil_wvalid = 1'b0; end
            t++;
            if (!aw_done && t >= w_lead) s_axil_awvalid = 1'b1;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        t = 0;
        while (aw_done && w_done && t < 400) begin
            @(negedge clk);
            if (s_axil_bvalid) begin
                if (!seen) begin
                    seen = 1; resp = s_axil_bresp; lat = cyc - hs_cyc; b_cyc = cyc;
                end else begin
                    n_cmp++;
                    if (s_axil_bresp !== resp) begin
                        n_err++; $display("FAIL b_stable: bresp %b, required %b", s_axil_bresp, resp);
                    end
                end
                if (s_axil_bready) begin got_b = 1; break; end
                waited++;
            end else if (seen) begin
                n_cmp++; n_err++; $display("FAIL b_dropped: bvalid 0 before bready, required 1");
                break;
            end
            @(posedge clk); #1;
            if (waited >= b_hold) s_axil_bready = 1'b1;
            t++;
        end
        if (got_b) begin
            @(posedge clk); #1;
        end else begin
            n_cmp++; n_err++; $display("FAIL b_timeout: no B handshake for addr %h, required one", a);
        end
        s_axil_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [63:0] a, output logic [31:0] d, output logic [1:0] r, output int lat);
        int t; int hs;
        t = 0; hs = -1; lat = -1; d = 'x; r = 'x;
        s_axil_araddr = a; s_axil_arprot = 3'($urandom); s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
        while (hs < 0 && t < 400) begin
            @(negedge clk);
            if (s_axil_arready) hs = cyc;
            @(posedge clk); #1;
            t++;
        end
        s_axil_arvalid = 1'b0;
        while (hs >= 0 && t < 400) begin
            @(negedge clk);
            if (s_axil_rvalid) begin d = s_axil_rdata; r = s_axil_rresp; lat = cyc - hs; break; end
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
    endtask

    task automatic resp_push(input logic [31:0] d, output bit ok);
        resp_v_i = 1'b1; resp_data_i = d;
        @(negedge clk);
        ok = resp_ready_and_o;
        @(posedge clk); #1;
        resp_v_i = 1'b0;
    endtask

    task automatic push_and_pop(input logic [31:0] d, output bit push_rdy, output bit rv, output logic [31:0] rd);
        resp_v_i = 1'b1; resp_data_i = d; s_axil_araddr = 64'h14; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
        @(negedge clk);
        push_rdy = resp_ready_and_o && s_axil_arready;
        @(posedge clk); #1;
        resp_v_i = 1'b0; s_axil_arvalid = 1'b0;
        @(negedge clk);
        rv = s_axil_rvalid; rd = s_axil_rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, nbf_v_o, resp_ready_and_o, done_o} !== 8'b1110_0010) begin
            n_err++; $display("FAIL reset_ctrl: aw/w/ar/b/r/nbf_v/resp_rdy/done = %b, required 11100010",
                {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid, nbf_v_o, resp_ready_and_o, done_o});
        end
        n_cmp++;
        if (nbf_o !== 136'h0) begin n_err++; $display("FAIL reset_nbf: got %h, required 0", nbf_o); end
        n_cmp++;
        if ({s_axil_rdata, s_axil_bresp, s_axil_rresp} !== 36'h0) begin
            n_err++; $display("FAIL reset_resp: rdata %h bresp %b rresp %b, required 0", s_axil_rdata, s_axil_bresp, s_axil_rresp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input int w_lead, input int b_hold);
        logic [31:0] w[5]; logic [1:0] er, r; int lat, bc;
        logic [135:0] want;
        w[0] = 32'h89ABCDEF; w[1] = 32'h01234567; w[2] = 32'h80000000; w[3] = 32'h0; w[4] = 32'h03;
        want = {8'h03, 64'h0000000080000000, 64'h0123456789ABCDEF};
        for (int i = 0; i < 5; i++) begin
            model_write(HOST, w[i], er);
            axi_write(HOST, w[i], w_lead, b_hold, r, lat, bc);
            n_cmp++;
            if (r !== er) begin n_err++; $display("FAIL basic_bresp: flit %0d got %b, required %b", i, r, er); end
            if (w_lead == 0) begin
                n_cmp++;
                if (lat !== 2) begin n_err++; $display("FAIL basic_b_latency: got %0d, required 2", lat); end
            end
        end
        if (w_lead == 0) begin
            n_cmp++;
            if (rise_cyc !== bc) begin n_err++; $display("FAIL nbf_v_timing: nbf_v rose at %0d, required %0d", rise_cyc, bc); end
        end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0 || last_nbf !== want) begin
            n_err++; $display("FAIL basic_cmd: last %h pending %0d, required %h pending 0", last_nbf, exp_q.size(), want);
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] w[5]; logic [1:0] er, r; int lat, bc;
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                model_write(64'h20, 32'hDEADBEEF, er);
                axi_write(64'h20, 32'hDEADBEEF, 0, 0, r, lat, bc);
                n_cmp++;
                if (r !== 2'b10) begin n_err++; $display("FAIL bad_addr_slverr: got %b, required 10", r); end
            end else begin
                model_write(HOST, w[i > 2 ? i-1 : i], er);
                axi_write(HOST, w[i > 2 ? i-1 : i], 0, 0, r, lat, bc);
                n_cmp++;
                if (r !== er) begin n_err++; $display("FAIL bad_addr_bresp: got %b, required %b", r, er); end
            end
        end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bad_addr_pending: %0d commands, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[10]; logic [1:0] er; int acc[$]; int nb, nok, t, k; bit hs;
        for (int i = 0; i < 10; i++) begin w[i] = $urandom; model_write(HOST, w[i], er); end
        nbf_ready_and_i = 1'b1; s_axil_bready = 1'b1;
        k = 0; nb = 0; nok = 0; t = 0;
        s_axil_awaddr = HOST; s_axil_wdata = w[0]; s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        while ((k < 10 || nb < 10) && t < 200) begin
            @(negedge clk);
            if (s_axil_bvalid) begin nb++; if (s_axil_bresp == 2'b00) nok++; end
            hs = s_axil_awvalid && s_axil_awready && s_axil_wvalid && s_axil_wready;
            if (hs) acc.push_back(cyc);
            @(posedge clk); #1;
            if (hs) begin
                k++;
                if (k < 10) s_axil_wdata = w[k];
                else begin s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; end
            end
            t++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
        n_cmp++;
        if (nb != 10 || nok != 10 || acc.size() != 10) begin
            n_err++; $display("FAIL b2b_counts: B %0d OKAY %0d accepts %0d, required 10/10/10", nb, nok, acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] != 2) begin n_err++; $display("FAIL b2b_rate: flit %0d spacing %0d, required 2", i, acc[i] - acc[i-1]); end
        end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: %0d commands, required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic [31:0] w[10]; int sent; bit found; int t; logic [135:0] held;
        for (int i = 0; i < 10; i++) w[i] = $urandom;
        nbf_ready_and_i = 1'b0; sent = 0; found = 0;
        fork
            begin
                logic [1:0] er, r; int lat, bc;
                for (int i = 0; i < 10; i++) begin
                    sent = i;
                    model_write(HOST, w[i], er);
                    axi_write(HOST, w[i], 0, 0, r, lat, bc);
                    n_cmp++;
                    if (r !== er) begin n_err++; $display("FAIL stall_bresp: flit %0d got %b, required %b", i, r, er); end
                end
            end
            begin
                t = 0;
                while (!found && t < 1000) begin
                    @(negedge clk);
                    if (sent == 9 && nbf_v_o && !s_axil_awready && !s_axil_wready) found = 1;
                    t++;
                end
                n_cmp++;
                if (!found) begin
                    n_err++; $display("FAIL stall_reached: word 4 never stalled, required aw/w ready low");
                end else begin
                    held = nbf_o;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        n_cmp++;
                        if ({s_axil_awready, s_axil_wready, nbf_v_o} !== 3'b001 || nbf_o !== held) begin
                            n_err++; $display("FAIL stall_hold: aw/w/v %b nbf %h, required 001 %h",
                                {s_axil_awready, s_axil_wready, nbf_v_o}, nbf_o, held);
                        end
                    end
                end
                @(posedge clk); #1;
                nbf_ready_and_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_pending: %0d commands, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic [63:0] a; logic [1:0] er, r; int lat, bc; bit stop;
        stop = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    a = ($urandom_range(0, 4) == 0) ? ({$urandom, $urandom} | 64'h4) : HOST;
                    d = $urandom;
                    model_write(a, d, er);
                    axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), r, lat, bc);
                    n_cmp++;
                    if (r !== er) begin n_err++; $display("FAIL random_bresp: addr %h got %b, required %b", a, r, er); end
                end
                stop = 1;
            end
            begin
                while (!stop) begin @(posedge clk); #1; nbf_ready_and_i = 1'($urandom_range(0, 1)); end
                nbf_ready_and_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL random_pending: %0d commands, required 0", exp_q.size()); end
    endtask

    task automatic test_fifo();
        logic [31:0] d, exp_d; logic [1:0] r; int lat; bit ok, exp_ok, rv;
        logic [31:0] init_vals[3];
        init_vals[0] = 32'h11; init_vals[1] = 32'h22; init_vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            exp_ok = fifo_q.size() < 16;
            resp_push(init_vals[i], ok);
            if (exp_ok) fifo_q.push_back(init_vals[i]);
            n_cmp++;
            if (ok !== exp_ok) begin n_err++; $display("FAIL fifo_push_rdy: got %b, required %b", ok, exp_ok); end
        end
        axi_read(64'h10, d, r, lat);
        n_cmp++;
        if (d !== 32'(fifo_q.size()) || r !== 2'b00 || lat !== 1) begin
            n_err++; $display("FAIL fifo_count: data %0d resp %b lat %0d, required %0d 00 1", d, r, lat, fifo_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
            axi_read(64'h14, d, r, lat);
            n_cmp++;
            if (d !== exp_d || r !== 2'b00) begin n_err++; $display("FAIL fifo_pop: read %0d got %h/%b, required %h/00", i, d, r, exp_d); end
        end
        axi_read(64'h30, d, r, lat);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b10) begin n_err++; $display("FAIL read_bad_addr: got %h/%b, required 0/10", d, r); end
        push_and_pop(32'hA5A5_0001, ok, rv, d);
        exp_d = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
        fifo_q.push_back(32'hA5A5_0001);
        n_cmp++;
        if (!ok || !rv || d !== exp_d) begin n_err++; $display("FAIL fifo_pp_empty: rdy %b rv %b data %h, required 1 1 %h", ok, rv, d, exp_d); end
        for (int i = 0; i < 17; i++) begin
            d = $urandom;
            exp_ok = fifo_q.size() < 16;
            resp_push(d, ok);
            if (exp_ok) fifo_q.push_back(d);
            n_cmp++;
            if (ok !== exp_ok) begin n_err++; $display("FAIL fifo_fill_rdy: push %0d got %b, required %b", i, ok, exp_ok); end
        end
        push_and_pop(32'h5A5A_0002, ok, rv, d);
        exp_d = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
        fifo_q.push_back(32'h5A5A_0002);
        n_cmp++;
        if (!ok || !rv || d !== exp_d) begin n_err++; $display("FAIL fifo_pp_full: rdy %b rv %b data %h, required 1 1 %h", ok, rv, d, exp_d); end
        axi_read(64'h10, d, r, lat);
        n_cmp++;
        if (d !== 32'(fifo_q.size())) begin n_err++; $display("FAIL fifo_full_count: got %0d, required %0d", d, fifo_q.size()); end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                exp_ok = fifo_q.size() < 16;
                resp_push(d, ok);
                if (exp_ok) fifo_q.push_back(d);
                n_cmp++;
                if (ok !== exp_ok) begin n_err++; $display("FAIL fifo_rand_rdy: got %b, required %b", ok, exp_ok); end
            end else begin
                exp_d = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'h0;
                axi_read(64'h14, d, r, lat);
                n_cmp++;
                if (d !== exp_d) begin n_err++; $display("FAIL fifo_rand_pop: got %h, required %h", d, exp_d); end
            end
        end
    endtask

    task automatic test_finish_reset();
        logic [31:0] d; logic [1:0] er, r; int lat, bc; bit ok;
        for (int i = 0; i < 5; i++) begin
            d = (i == 4) ? (($urandom & 32'hFFFF_FF00) | 32'hFF) : $urandom;
            model_write(HOST, d, er);
            axi_write(HOST, d, 0, 0, r, lat, bc);
        end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (done_o !== exp_done || exp_q.size() != 0) begin
            n_err++; $display("FAIL finish_done: done %b pending %0d, required %b 0", done_o, exp_q.size(), exp_done);
        end
        for (int i = 0; i < 2; i++) begin d = $urandom; model_write(HOST, d, er); axi_write(HOST, d, 0, 0, r, lat, bc); end
        resp_push(32'h77, ok);
        s_axil_awaddr = HOST; s_axil_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axil_awvalid = 1'b0;
        #2 rst_n = 1'b0;
        flit_k = 0; exp_done = 1'b0; fifo_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({done_o, s_axil_awready, s_axil_bvalid, nbf_v_o} !== 4'b0100) begin
            n_err++; $display("FAIL reset_mid: done/awready/bvalid/v %b, required 0100", {done_o, s_axil_awready, s_axil_bvalid, nbf_v_o});
        end
        @(posedge clk); #1;
        axi_read(64'h10, d, r, lat);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_fifo: count %0d, required 0", d); end
        for (int i = 0; i < 5; i++) begin d = $urandom; model_write(HOST, d, er); axi_write(HOST, d, 0, 0, r, lat, bc); end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL reset_counter: %0d commands pending, required 0", exp_q.size()); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_awprot = '0;
        s_axil_wdata = '0;  s_axil_wvalid = 1'b0;  s_axil_wstrb = '0; s_axil_bready = 1'b0;
        s_axil_araddr = '0; s_axil_arvalid = 1'b0; s_axil_arprot = '0; s_axil_rready = 1'b1;
        nbf_ready_and_i = 1'b1; resp_data_i = '0; resp_v_i = 1'b0;
        test_reset();
        test_basic(0, 0);
        test_basic(3, 4);
        test_bad_addr();
        test_back_to_back();
        test_stall();
        test_random();
        test_fifo();
        test_finish_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
